// File: rtl/lsu_wb.sv
// lsu_wb: load/store and write-back stage.
// Accepts one instruction per handshake from execute, issues at most one
// data-memory transaction for it, aligns/extends load data and drives the
// registered regfile write port. O_ls_addr reports the PC held in the stage.
//
// Handshakes:
//   execute -> stage : transfer when I_valid && O_ready (O_ready is high only
//                      in IDLE and outside reset; it never depends on I_valid).
//   stage -> memory  : O_mem_req is held with stable addr/we/wstrb/wdata until
//                      the cycle I_mem_gnt is seen. A load then waits in RESP
//                      for exactly one I_mem_rvalid. gnt is ignored outside
//                      REQ and rvalid is ignored outside RESP.
module lsu_wb #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_valid,
    output logic              O_ready,
    input  logic [DATA_W-1:0] I_inst_addr,
    input  logic              I_rd_we,
    input  logic [REG_AW-1:0] I_rd_waddr,
    input  logic [DATA_W-1:0] I_alu_res,
    input  logic              I_mem_re,
    input  logic              I_mem_we,
    input  logic [1:0]        I_mem_size,
    input  logic              I_mem_unsigned,
    input  logic [DATA_W-1:0] I_store_data,
    output logic              O_mem_req,
    input  logic              I_mem_gnt,
    output logic [DATA_W-1:0] O_mem_addr,
    output logic              O_mem_we,
    output logic [3:0]        O_mem_wstrb,
    output logic [DATA_W-1:0] O_mem_wdata,
    input  logic              I_mem_rvalid,
    input  logic [DATA_W-1:0] I_mem_rdata,
    output logic              O_rd_we,
    output logic [REG_AW-1:0] O_rd_waddr,
    output logic [DATA_W-1:0] O_rd_wdata,
    output logic [DATA_W-1:0] O_ls_addr,
    output logic              O_misalign,
    output logic [1:0]        O_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Instruction latched at accept
    logic [DATA_W-1:0] r_pc;
    logic              r_inst_rd_we;
    logic [REG_AW-1:0] r_inst_rd;
    logic [DATA_W-1:0] r_ea;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_store_data;
    logic              r_is_load;

    // Registered outputs
    logic              r_rd_we;
    logic [REG_AW-1:0] r_rd_waddr;
    logic [DATA_W-1:0] r_rd_wdata;
    logic [DATA_W-1:0] r_ls_addr;
    logic              r_misalign;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_misalign_in;
    logic [7:0]        w_lb;
    logic [15:0]       w_lh;
    logic [DATA_W-1:0] w_load_data;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;

    assign O_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept = I_valid && O_ready;
    assign w_is_mem = I_mem_re || I_mem_we;

    // Half needs ea[0]==0; word (size 2 or 3) needs ea[1:0]==0
    assign w_misalign_in = w_is_mem &&
                           (((I_mem_size == 2'd1) && I_alu_res[0]) ||
                            (I_mem_size[1] && (I_alu_res[1:0] != 2'b00)));

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mem && !w_misalign_in) w_state_nxt = S_REQ;
            S_REQ:  if (I_mem_gnt) w_state_nxt = r_is_load ? S_RESP : S_IDLE;
            S_RESP: if (I_mem_rvalid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Latch the incoming instruction on every accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= '0;
            r_inst_rd_we <= 1'b0;
            r_inst_rd    <= '0;
            r_ea         <= '0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_store_data <= '0;
            r_is_load    <= 1'b0;
        end else if (w_accept) begin
            r_pc         <= I_inst_addr;
            r_inst_rd_we <= I_rd_we;
            r_inst_rd    <= I_rd_waddr;
            r_ea         <= I_alu_res;
            r_size       <= I_mem_size;
            r_unsigned   <= I_mem_unsigned;
            r_store_data <= I_store_data;
            r_is_load    <= I_mem_re;  // load wins when both re and we are set
        end
    end

    // Load alignment and sign/zero extension from the latched address
    always_comb begin
        w_lb        = I_mem_rdata[{r_ea[1:0], 3'b000} +: 8];
        w_lh        = r_ea[1] ? I_mem_rdata[31:16] : I_mem_rdata[15:0];
        w_load_data = I_mem_rdata;
        case (r_size)
            2'd0:    w_load_data = {{(DATA_W-8){w_lb[7] & ~r_unsigned}}, w_lb};
            2'd1:    w_load_data = {{(DATA_W-16){w_lh[15] & ~r_unsigned}}, w_lh};
            default: w_load_data = I_mem_rdata;
        endcase
    end

    // Store byte enables and lane-replicated data from the latched operands
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = r_store_data;
        case (r_size)
            2'd0: begin
                w_wstrb = 4'b0001 << r_ea[1:0];
                w_wdata = {4{r_store_data[7:0]}};
            end
            2'd1: begin
                w_wstrb = r_ea[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_store_data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = r_store_data;
            end
        endcase
    end

    // Memory port: driven from latched state only, zero whenever no request
    always_comb begin
        O_mem_req   = 1'b0;
        O_mem_addr  = '0;
        O_mem_we    = 1'b0;
        O_mem_wstrb = 4'b0000;
        O_mem_wdata = '0;
        if (r_state == S_REQ) begin
            O_mem_req  = 1'b1;
            O_mem_addr = {r_ea[DATA_W-1:2], 2'b00};
            if (!r_is_load) begin
                O_mem_we    = 1'b1;
                O_mem_wstrb = w_wstrb;
                O_mem_wdata = w_wdata;
            end
        end
    end

    // Write-back port, misalign pulse and in-stage PC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_we    <= 1'b0;
            r_rd_waddr <= '0;
            r_rd_wdata <= '0;
            r_ls_addr  <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_rd_we    <= 1'b0;
            r_misalign <= 1'b0;
            // PC stays visible through the completion cycle of a memory op
            if (r_state != S_IDLE)
                r_ls_addr <= r_pc;
            else if (w_accept && !w_misalign_in)
                r_ls_addr <= I_inst_addr;
            else
                r_ls_addr <= '0;

            if (w_accept && !w_is_mem) begin
                r_rd_we    <= I_rd_we && (I_rd_waddr != '0);
                r_rd_waddr <= I_rd_waddr;
                r_rd_wdata <= I_alu_res;
            end else if (w_accept && w_misalign_in) begin
                r_misalign <= 1'b1;
            end else if ((r_state == S_RESP) && I_mem_rvalid) begin
                r_rd_we    <= r_inst_rd_we && (r_inst_rd != '0);
                r_rd_waddr <= r_inst_rd;
                r_rd_wdata <= w_load_data;
            end
        end
    end

    assign O_rd_we     = r_rd_we;
    assign O_rd_waddr  = r_rd_waddr;
    assign O_rd_wdata  = r_rd_wdata;
    assign O_ls_addr   = r_ls_addr;
    assign O_misalign  = r_misalign;
    assign O_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: directed bench for lsu_wb. Single-cycle ops come from a vector
// table; loads, stores and reset-during-transaction are hand sequences.
module tb_lsu_wb;

    logic        clk;
    logic        rst;
    logic        I_valid;
    logic        O_ready;
    logic [31:0] I_inst_addr;
    logic        I_rd_we;
    logic [4:0]  I_rd_waddr;
    logic [31:0] I_alu_res;
    logic        I_mem_re;
    logic        I_mem_we;
    logic [1:0]  I_mem_size;
    logic        I_mem_unsigned;
    logic [31:0] I_store_data;
    logic        O_mem_req;
    logic        I_mem_gnt;
    logic [31:0] O_mem_addr;
    logic        O_mem_we;
    logic [3:0]  O_mem_wstrb;
    logic [31:0] O_mem_wdata;
    logic        I_mem_rvalid;
    logic [31:0] I_mem_rdata;
    logic        O_rd_we;
    logic [4:0]  O_rd_waddr;
    logic [31:0] O_rd_wdata;
    logic [31:0] O_ls_addr;
    logic        O_misalign;
    logic [1:0]  O_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected write-backs {waddr, wdata}, in order
    logic [36:0] exp_q[$];

    lsu_wb dut (
        .clk(clk), .rst(rst),
        .I_valid(I_valid), .O_ready(O_ready),
        .I_inst_addr(I_inst_addr), .I_rd_we(I_rd_we), .I_rd_waddr(I_rd_waddr),
        .I_alu_res(I_alu_res), .I_mem_re(I_mem_re), .I_mem_we(I_mem_we),
        .I_mem_size(I_mem_size), .I_mem_unsigned(I_mem_unsigned),
        .I_store_data(I_store_data),
        .O_mem_req(O_mem_req), .I_mem_gnt(I_mem_gnt), .O_mem_addr(O_mem_addr),
        .O_mem_we(O_mem_we), .O_mem_wstrb(O_mem_wstrb), .O_mem_wdata(O_mem_wdata),
        .I_mem_rvalid(I_mem_rvalid), .I_mem_rdata(I_mem_rdata),
        .O_rd_we(O_rd_we), .O_rd_waddr(O_rd_waddr), .O_rd_wdata(O_rd_wdata),
        .O_ls_addr(O_ls_addr), .O_misalign(O_misalign), .O_dbg_state(O_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        I_valid        = 1'b0;
        I_inst_addr    = 32'h0;
        I_rd_we        = 1'b0;
        I_rd_waddr     = 5'd0;
        I_alu_res      = 32'h0;
        I_mem_re       = 1'b0;
        I_mem_we       = 1'b0;
        I_mem_size     = 2'd0;
        I_mem_unsigned = 1'b0;
        I_store_data   = 32'h0;
        I_mem_gnt      = 1'b0;
        I_mem_rvalid   = 1'b0;
        I_mem_rdata    = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},    {31'b0, O_mem_req}, 32'h0);
        check({tag, "_addr"},   O_mem_addr, 32'h0);
        check({tag, "_mwe"},    {31'b0, O_mem_we}, 32'h0);
        check({tag, "_wstrb"},  {28'b0, O_mem_wstrb}, 32'h0);
        check({tag, "_wdata"},  O_mem_wdata, 32'h0);
        check({tag, "_rd_we"},  {31'b0, O_rd_we}, 32'h0);
        check({tag, "_waddr"},  {27'b0, O_rd_waddr}, 32'h0);
        check({tag, "_rwdata"}, O_rd_wdata, 32'h0);
        check({tag, "_ls"},     O_ls_addr, 32'h0);
        check({tag, "_mis"},    {31'b0, O_misalign}, 32'h0);
        check({tag, "_ready"},  {31'b0, O_ready}, 32'h0);
    endtask

    // Scoreboard: every write-back must match the head of exp_q
    always @(negedge clk) begin
        logic [36:0] e;
        if (O_rd_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL wb_unexpected actual=%h expected=none", {O_rd_waddr, O_rd_wdata});
            end else begin
                e = exp_q.pop_front();
                if ({O_rd_waddr, O_rd_wdata} !== e) begin
                    n_errors++;
                    $display("FAIL wb_value actual=%h expected=%h", {O_rd_waddr, O_rd_wdata}, e);
                end
            end
        end
    end

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        re;
        logic        we;
        logic [1:0]  size;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic        chk_ls;
        logic [31:0] e_ls;
    } vec_t;

    vec_t vecs[10];

    task automatic do_load(input string tag, input logic [31:0] pc, input logic [31:0] ea,
                           input logic [1:0] size, input logic uns, input logic also_we,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input int gnt_wait, input int rv_wait, input logic [31:0] exp_data);
        check({tag, "_ready_in"}, {31'b0, O_ready}, 32'h1);
        I_valid = 1'b1; I_inst_addr = pc; I_rd_we = 1'b1; I_rd_waddr = rd;
        I_alu_res = ea; I_mem_re = 1'b1; I_mem_we = also_we; I_mem_size = size;
        I_mem_unsigned = uns; I_store_data = 32'h5555_AAAA;
        step();
        clear_inputs();
        for (int i = 0; i <= gnt_wait; i++) begin
            check({tag, "_req"},   {31'b0, O_mem_req}, 32'h1);
            check({tag, "_addr"},  O_mem_addr, {ea[31:2], 2'b00});
            check({tag, "_mwe"},   {31'b0, O_mem_we}, 32'h0);
            check({tag, "_busy"},  {31'b0, O_ready}, 32'h0);
            check({tag, "_ls"},    O_ls_addr, pc);
            if (i == gnt_wait) I_mem_gnt = 1'b1;
            step();
        end
        I_mem_gnt = 1'b0;
        check({tag, "_req_drop"}, {31'b0, O_mem_req}, 32'h0);
        for (int i = 1; i < rv_wait; i++) begin
            check({tag, "_wait"}, {31'b0, O_ready}, 32'h0);
            I_mem_gnt = 1'b1;  // must be ignored while waiting for data
            step();
        end
        I_mem_gnt = 1'b0;
        check({tag, "_no_early_wb"}, {31'b0, O_rd_we}, 32'h0);
        I_mem_rvalid = 1'b1; I_mem_rdata = rdata;
        if (rd != 5'd0) exp_q.push_back({rd, exp_data});
        step();
        I_mem_rvalid = 1'b0; I_mem_rdata = $urandom;
        check({tag, "_wb_we"}, {31'b0, O_rd_we}, {31'b0, rd != 5'd0});
        if (rd != 5'd0) begin
            check({tag, "_wb_addr"}, {27'b0, O_rd_waddr}, {27'b0, rd});
            check({tag, "_wb_data"}, O_rd_wdata, exp_data);
        end
        check({tag, "_ready_out"}, {31'b0, O_ready}, 32'h1);
        check({tag, "_ls_wb"}, O_ls_addr, pc);
        step();
        check({tag, "_wb_once"}, {31'b0, O_rd_we}, 32'h0);
        check({tag, "_ls_clr"}, O_ls_addr, 32'h0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] pc, input logic [31:0] ea,
                            input logic [1:0] size, input logic [31:0] d, input int gnt_wait,
                            input logic [3:0] e_strb, input logic [31:0] e_wdata);
        check({tag, "_ready_in"}, {31'b0, O_ready}, 32'h1);
        I_valid = 1'b1; I_inst_addr = pc; I_rd_we = 1'b1; I_rd_waddr = 5'd20;
        I_alu_res = ea; I_mem_re = 1'b0; I_mem_we = 1'b1; I_mem_size = size;
        I_store_data = d;
        step();
        clear_inputs();
        for (int i = 0; i <= gnt_wait; i++) begin
            check({tag, "_req"},   {31'b0, O_mem_req}, 32'h1);
            check({tag, "_addr"},  O_mem_addr, {ea[31:2], 2'b00});
            check({tag, "_mwe"},   {31'b0, O_mem_we}, 32'h1);
            check({tag, "_strb"},  {28'b0, O_mem_wstrb}, {28'b0, e_strb});
            check({tag, "_wdata"}, O_mem_wdata, e_wdata);
            check({tag, "_ls"},    O_ls_addr, pc);
            check({tag, "_busy"},  {31'b0, O_ready}, 32'h0);
            if (i == gnt_wait) I_mem_gnt = 1'b1;
            else I_mem_rvalid = 1'b1;  // must be ignored while requesting
            step();
            I_mem_rvalid = 1'b0;
        end
        I_mem_gnt = 1'b0;
        check({tag, "_req_drop"},  {31'b0, O_mem_req}, 32'h0);
        check({tag, "_addr_zero"}, O_mem_addr, 32'h0);
        check({tag, "_strb_zero"}, {28'b0, O_mem_wstrb}, 32'h0);
        check({tag, "_ready_out"}, {31'b0, O_ready}, 32'h1);
        check({tag, "_no_wb"},     {31'b0, O_rd_we}, 32'h0);
        check({tag, "_ls_done"},   O_ls_addr, pc);
        step();
        check({tag, "_ls_clr"}, O_ls_addr, 32'h0);
    endtask

    initial begin
        //            valid pc           rdwe rd     alu           re    we    sz    e_we  e_wdata       mis   chkls e_ls
        vecs[0] = '{1'b1, 32'h0000_0100, 1'b1, 5'd5, 32'h0000_0011, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0011, 1'b0, 1'b1, 32'h0000_0100};
        vecs[1] = '{1'b1, 32'h0000_0104, 1'b1, 5'd6, 32'h0000_0022, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0022, 1'b0, 1'b1, 32'h0000_0104};
        vecs[2] = '{1'b1, 32'h0000_0108, 1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0108};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_010C, 1'b1, 5'd8, 32'h8000_0002, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_0110, 1'b1, 5'd7, 32'h0000_0033, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0033, 1'b0, 1'b1, 32'h0000_0110};
        vecs[6] = '{1'b1, 32'h0000_0114, 1'b0, 5'd0, 32'h8000_0101, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0118, 1'b0, 5'd0, 32'h8000_0006, 1'b0, 1'b1, 2'd3, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 32'h0000_011C, 1'b0, 5'd9, 32'h0000_0044, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_011C};
        vecs[9] = '{1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0};

        // Reset
        rst = 1'b1;
        clear_inputs();
        step();
        check_all_zero("rst0");
        step();
        check_all_zero("rst1");
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, O_ready}, 32'h1);

        // Single-cycle ops, back to back
        for (int i = 0; i < 10; i++) begin
            check($sformatf("vec%0d_ready", i), {31'b0, O_ready}, 32'h1);
            I_valid = vecs[i].valid; I_inst_addr = vecs[i].pc; I_rd_we = vecs[i].rd_we;
            I_rd_waddr = vecs[i].rd; I_alu_res = vecs[i].alu; I_mem_re = vecs[i].re;
            I_mem_we = vecs[i].we; I_mem_size = vecs[i].size; I_mem_unsigned = 1'b0;
            I_store_data = 32'h1357_9BDF;
            if (vecs[i].e_we) exp_q.push_back({vecs[i].rd, vecs[i].e_wdata});
            step();
            check($sformatf("vec%0d_rd_we", i), {31'b0, O_rd_we}, {31'b0, vecs[i].e_we});
            check($sformatf("vec%0d_mis", i), {31'b0, O_misalign}, {31'b0, vecs[i].e_mis});
            check($sformatf("vec%0d_req", i), {31'b0, O_mem_req}, 32'h0);
            if (vecs[i].chk_ls) check($sformatf("vec%0d_ls", i), O_ls_addr, vecs[i].e_ls);
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d_waddr", i), {27'b0, O_rd_waddr}, {27'b0, vecs[i].rd});
                check($sformatf("vec%0d_wdata", i), O_rd_wdata, vecs[i].e_wdata);
            end
        end
        clear_inputs();

        // Loads
        do_load("lb",   32'h0000_0300, 32'h8000_0003, 2'd0, 1'b0, 1'b0, 5'd10, 32'h80FF_FF7F, 0, 2, 32'hFFFF_FF80);
        do_load("lbu",  32'h0000_0304, 32'h8000_0003, 2'd0, 1'b1, 1'b0, 5'd11, 32'h80FF_FF7F, 0, 2, 32'h0000_0080);
        do_load("lh",   32'h0000_0308, 32'h8000_0002, 2'd1, 1'b0, 1'b0, 5'd12, 32'h80FF_FF7F, 1, 1, 32'hFFFF_80FF);
        do_load("lhu",  32'h0000_030C, 32'h8000_0000, 2'd1, 1'b1, 1'b0, 5'd13, 32'h80FF_FF7F, 0, 1, 32'h0000_FF7F);
        do_load("lw_rw",32'h0000_0310, 32'h8000_0004, 2'd2, 1'b0, 1'b1, 5'd14, 32'h1234_5678, 2, 3, 32'h1234_5678);
        do_load("lb1",  32'h0000_0314, 32'h8000_0001, 2'd0, 1'b0, 1'b0, 5'd15, 32'h80FF_FF7F, 0, 1, 32'hFFFF_FFFF);
        do_load("lb0",  32'h0000_0318, 32'h8000_0000, 2'd0, 1'b0, 1'b0, 5'd16, 32'h80FF_FF7F, 0, 1, 32'h0000_007F);
        do_load("ld_x0",32'h0000_031C, 32'h8000_0000, 2'd2, 1'b0, 1'b0, 5'd0,  32'hCAFE_F00D, 0, 1, 32'h0);

        // Stores
        do_store("sh", 32'h0000_0400, 32'h8000_0102, 2'd1, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
        do_store("sb", 32'h0000_0404, 32'h8000_0001, 2'd0, 32'h0000_00EF, 0, 4'b0010, 32'hEFEF_EFEF);
        do_store("sw", 32'h0000_0408, 32'h8000_0008, 2'd3, 32'hCAFE_BABE, 1, 4'b1111, 32'hCAFE_BABE);
        do_store("sh0",32'h0000_040C, 32'h8000_0000, 2'd1, 32'h0000_5A5A, 0, 4'b0011, 32'h5A5A_5A5A);

        // Reset while waiting for load data, then a late rvalid
        I_valid = 1'b1; I_inst_addr = 32'h0000_0500; I_rd_we = 1'b1; I_rd_waddr = 5'd17;
        I_alu_res = 32'h8000_0010; I_mem_re = 1'b1; I_mem_size = 2'd2;
        step();
        clear_inputs();
        check("rr_req", {31'b0, O_mem_req}, 32'h1);
        I_mem_gnt = 1'b1;
        step();
        I_mem_gnt = 1'b0;
        check("rr_in_resp", {31'b0, O_ready}, 32'h0);
        rst = 1'b1;
        step();
        check_all_zero("rr_rst0");
        step();
        check_all_zero("rr_rst1");
        rst = 1'b0;
        #1;
        check("rr_ready", {31'b0, O_ready}, 32'h1);
        step();
        I_mem_rvalid = 1'b1; I_mem_rdata = 32'h7777_7777;
        step();
        I_mem_rvalid = 1'b0;
        check("rr_late_rvalid", {31'b0, O_rd_we}, 32'h0);
        check("rr_ready_after", {31'b0, O_ready}, 32'h1);
        step();
        check("rr_idle_req", {31'b0, O_mem_req}, 32'h0);

        check("exp_q_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/store and write-back stage between execute and the register file. It accepts one retired-from-execute instruction per handshake and issues at most one data-memory transaction for it. It aligns and extends load data, then drives the regfile write port (`rd_we`/`rd_waddr`/`rd_wdata`). It also reports the PC held in the stage on `O_ls_addr`, which feeds the regfile commit-PC tracking; the value is 0 when the stage is empty.

## Interface
- `DATA_W`, 32, data/address width
- `REG_AW`, 5, register address width
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `I_valid`  in  1  execute result valid
- `O_ready`  out  1  stage can accept; equals (state==IDLE && !rst)
- `I_inst_addr`  in  32  PC of the incoming instruction
- `I_rd_we`  in  1  instruction writes rd
- `I_rd_waddr`  in  5  rd index
- `I_alu_res`  in  32  ALU result, or effective address for memory ops
- `I_mem_re`  in  1  load
- `I_mem_we`  in  1  store
- `I_mem_size`  in  2  0 byte, 1 half, 2 word (3 treated as word)
- `I_mem_unsigned`  in  1  zero-extend load (lbu/lhu)
- `I_store_data`  in  32  rs2 value for stores
- `O_mem_req`  out  1  memory request
- `I_mem_gnt`  in  1  request accepted this cycle
- `O_mem_addr`  out  32  word-aligned address {ea[31:2],2'b00}
- `O_mem_we`  out  1  1 = store
- `O_mem_wstrb`  out  4  byte enables
- `O_mem_wdata`  out  32  lane-replicated store data
- `I_mem_rvalid`  in  1  load data valid
- `I_mem_rdata`  in  32  load word
- `O_rd_we`  out  1  regfile write enable (registered)
- `O_rd_waddr`  out  5  regfile write address (registered)
- `O_rd_wdata`  out  32  regfile write data (registered)
- `O_ls_addr`  out  32  PC held in the stage, 0 when empty
- `O_misalign`  out  1  one-cycle pulse on a misaligned access

## Operation
- FSM states:
  - IDLE: accepts `I_valid`.
  - REQ: `O_mem_req`=1, held until `I_mem_gnt`.
  - RESP: waits for `I_mem_rvalid`.
- Accept happens when `I_valid && O_ready`. On accept the stage latches all inputs.
- Non-memory op: stays in IDLE. The next cycle gives `O_rd_we`=`I_rd_we`, `O_rd_wdata`=`I_alu_res`. Throughput is 1/cycle.
- Load: IDLE→REQ. On `gnt`, REQ→RESP. On `rvalid`, RESP→IDLE and the aligned result is written back.
- Store: IDLE→REQ. On `gnt`, REQ→IDLE. No rd write.
- If both `I_mem_re` and `I_mem_we` are set, the load wins and the store is dropped.
- Misalignment is half with ea[0]=1, or word with ea[1:0]≠0. Such an access issues no request and no rd write, stays in IDLE, and pulses `O_misalign` the next cycle.
- `O_rd_we` is forced 0 when rd==0.
- Store strobes:
  - byte: 4'b0001<<ea[1:0], wdata={4{d[7:0]}}
  - half: ea[1]?1100:0011, wdata={2{d[15:0]}}
  - word: 1111, wdata=d
- Load extract:
  - byte: lane ea[1:0]
  - half: lane ea[1]
  - Sign-extend unless `I_mem_unsigned`; word passes through.
- `O_mem_addr`/`we`/`wstrb`/`wdata` are stable while `O_mem_req`=1, and 0 when `O_mem_req`=0.
- `I_mem_rvalid` is ignored outside RESP. `I_mem_gnt` is ignored outside REQ.
- `O_ls_addr`:
  - Load/store: latched PC from the cycle after accept through the write-back/grant-completion cycle.
  - Non-mem op: PC for the single cycle after accept.
  - 0 otherwise.

## Timing
- Reset: state=IDLE and every output is 0. `O_ready`=0 during rst and goes to 1 in the first cycle after reset.
- Reset mid-transaction: the transaction is abandoned and `O_mem_req` drops the cycle after rst is sampled. A late `rvalid` after reset is ignored.
- Non-mem op accepted at cycle N: `O_rd_we` is high at N+1 only.
- Load accepted at N:
  - `O_mem_req` rises at N+1.
  - A grant at G gives `O_mem_req`=0 at G+1.
  - `rvalid` is accepted at ≥G+1.
  - `rvalid` at R gives `O_rd_we`=1 at R+1, with `O_ready`=1 at R+1.
  - Minimum latency accept→write-back is 3 cycles (gnt at N+1, rvalid at N+2, write at N+3).
- Store accepted at N: req rises at N+1. A grant at G gives `O_ready`=1 at G+1.
- `rvalid` may arrive in any cycle after gnt. The response wait is unbounded, with no timeout.
- `O_rd_we` is never high for more than one cycle per instruction.

## Test plan
- Back-to-back ALU ops (rd=5, 0x11; rd=6, 0x22), valid at cycles 1,2 → `O_rd_we` at 2,3 with matching addr/data, and `O_ready` held at 1.
- lb at ea=0x80000003, rdata=0x80FF_FF7F, gnt same cycle as req, rvalid 2 cycles later → rd written 0xFFFFFF80. The same access as lbu gives 0x00000080.
- sh, ea=0x80000102, d=0x1234ABCD, gnt delayed 3 cycles → `O_mem_addr`=0x80000100, `wstrb`=1100, `wdata`=0xABCDABCD, held stable through the stall. No rd write.
- lw at ea=0x80000002 → `O_misalign` pulse at N+1, no `O_mem_req`, no `O_rd_we`, and the next instruction is accepted at N+1.
- rst asserted in RESP, then `rvalid` 1 cycle after rst releases → no `O_rd_we`, all outputs 0 during reset, `O_ready`=1 after.
- ALU op with rd=0, value 0xDEAD → `O_rd_we` stays 0, and `O_ls_addr` equals the PC for exactly one cycle.
